// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, enable levels and state encodings for the register file
package regfile_pkg;

  localparam int unsigned REG_BUS_W   = 32;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned REG_NUM_DEF = 32;

  typedef logic [REG_BUS_W-1:0]  reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_bus_t  ZERO_WORD    = '0;
  localparam reg_addr_t ZERO_ADDR    = '0;
  localparam reg_addr_t LAST_ADDR    = 5'd31;
  localparam logic      RST_ENABLE   = 1'b0;
  localparam logic      WRITE_ENABLE = 1'b1;
  localparam logic      READ_ENABLE  = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 2R1W register file with zero register, write-through bypass and post-reset clear
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned REG_NUM      = REG_NUM_DEF,
  parameter bit          CLR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [REG_BUS_W-1:0]  wdata_i,
  input  logic                  re1_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  output logic [REG_BUS_W-1:0]  rdata1_o,
  input  logic                  re2_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [REG_BUS_W-1:0]  rdata2_o,
  input  logic [REG_ADDR_W-1:0] dbg_addr_i,
  output logic [REG_BUS_W-1:0]  dbg_data_o,
  output logic                  ready_o
);

  state_e    state_q, state_d;
  reg_addr_t clr_cnt_q, clr_cnt_d;
  reg_bus_t  dbg_data_q, dbg_data_d;

  logic      mem_we;
  reg_addr_t mem_waddr;
  reg_bus_t  mem_wdata;
  reg_bus_t  mem [REG_NUM];

  logic      port_open;
  logic      wr_req;
  logic      rd1_hit, rd2_hit;

  function automatic logic in_range(input reg_addr_t a);
    return 32'(a) < REG_NUM;
  endfunction

  // State register, clear counter and registered debug read
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= CLR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt_q  <= ZERO_ADDR;
      dbg_data_q <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 5'd1;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = ST_READY;
      end
    end
  end

  always_comb begin
    ready_o   = (rst != RST_ENABLE) && (state_q == ST_READY);
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = ZERO_WORD;
    if (rst != RST_ENABLE) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = in_range(clr_cnt_q);
        mem_waddr = clr_cnt_q;
      end else if (wr_req && in_range(waddr_i)) begin
        mem_we    = 1'b1;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
      end
    end
  end

  // Storage carries no reset so it can map onto block RAM; the clear sequence zeroes it instead
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    dbg_data_d = ZERO_WORD;
    if (state_q == ST_READY && dbg_addr_i != ZERO_ADDR && in_range(dbg_addr_i)) begin
      dbg_data_d = mem[dbg_addr_i];
    end
  end

  assign dbg_data_o = dbg_data_q;

  assign port_open = (rst != RST_ENABLE) && (state_q == ST_READY);
  assign wr_req    = (we_i == WRITE_ENABLE) && (waddr_i != ZERO_ADDR);
  assign rd1_hit   = port_open && (re1_i == READ_ENABLE) && (raddr1_i != ZERO_ADDR);
  assign rd2_hit   = port_open && (re2_i == READ_ENABLE) && (raddr2_i != ZERO_ADDR);

  always_comb begin
    rdata1_o = ZERO_WORD;
    if (rd1_hit) begin
      if (wr_req && waddr_i == raddr1_i) begin
        rdata1_o = wdata_i;
      end else if (in_range(raddr1_i)) begin
        rdata1_o = mem[raddr1_i];
      end
    end
  end

  always_comb begin
    rdata2_o = ZERO_WORD;
    if (rd2_hit) begin
      if (wr_req && waddr_i == raddr2_i) begin
        rdata2_o = wdata_i;
      end else if (in_range(raddr2_i)) begin
        rdata2_o = mem[raddr2_i];
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - randomized self-checking bench for regfile against a behavioural model
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic [31:0] rdata1_o;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata2_o;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_data_o;
  logic        ready_o;

  logic        rst_nc;
  logic [31:0] nc_rdata1, nc_rdata2, nc_dbg;
  logic        nc_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  bit          m_ready;
  int          m_left;
  logic [31:0] m_dbg;

  regfile u_dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
    .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o), .ready_o(ready_o)
  );

  regfile #(.REG_NUM(32), .CLR_ON_RESET(1'b0)) u_dut_nc (
    .clk(clk), .rst(rst_nc), .we_i(1'b0), .waddr_i(5'd0), .wdata_i(32'd0),
    .re1_i(1'b0), .raddr1_i(5'd0), .rdata1_o(nc_rdata1),
    .re2_i(1'b0), .raddr2_i(5'd0), .rdata2_o(nc_rdata2),
    .dbg_addr_i(5'd0), .dbg_data_o(nc_dbg), .ready_o(nc_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model reacts to the inputs present before the edge, then the edge happens
  task automatic cycle();
    if (!rst) begin
      m_left  = 32;
      m_ready = 0;
      m_dbg   = 32'd0;
    end else if (!m_ready) begin
      m_mem[32 - m_left] = 32'd0;
      m_left  = m_left - 1;
      m_ready = (m_left == 0);
      m_dbg   = 32'd0;
    end else begin
      m_dbg = (dbg_addr_i != 0) ? m_mem[dbg_addr_i] : 32'd0;
      if (we_i && waddr_i != 0) m_mem[waddr_i] = wdata_i;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (!rst || !re || a == 0 || !m_ready) return 32'd0;
    if (we_i && waddr_i == a) return wdata_i;
    return m_mem[a];
  endfunction

  task automatic idle_inputs();
    we_i = 0; waddr_i = 0; wdata_i = 0;
    re1_i = 0; raddr1_i = 0; re2_i = 0; raddr2_i = 0; dbg_addr_i = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    cycle();
    cycle();
    re1_i = 1; raddr1_i = 5'd3; re2_i = 1; raddr2_i = 5'd17;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++;
    if (dbg_data_o !== 32'd0) begin errors++; $display("FAIL reset_dbg: got %h expected 0", dbg_data_o); end
    checks++;
    if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin
      errors++; $display("FAIL reset_reads: got %h/%h expected 0/0", rdata1_o, rdata2_o);
    end
  endtask

  task automatic run_clear(input string tag);
    for (int k = 1; k <= 32; k++) begin
      we_i = 1'($urandom); waddr_i = 5'($urandom); wdata_i = $urandom;
      re1_i = 1; raddr1_i = 5'($urandom_range(1, 31));
      re2_i = 1; raddr2_i = waddr_i;
      #1;
      checks++;
      if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin
        errors++; $display("FAIL %s_clear_reads edge %0d: got %h/%h expected 0/0", tag, k, rdata1_o, rdata2_o);
      end
      cycle();
      checks++;
      if (ready_o !== (k == 32)) begin
        errors++; $display("FAIL %s_ready_timing edge %0d: got %b expected %b", tag, k, ready_o, (k == 32));
      end
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 1; a < 32; a++) begin
      re1_i = 1; raddr1_i = 5'(a); re2_i = 1; raddr2_i = 5'(32 - a); dbg_addr_i = 5'(a);
      #1;
      checks++;
      if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin
        errors++; $display("FAIL %s_zero_reads addr %0d: got %h/%h expected 0/0", tag, a, rdata1_o, rdata2_o);
      end
      cycle();
      checks++;
      if (dbg_data_o !== 32'd0) begin
        errors++; $display("FAIL %s_zero_dbg addr %0d: got %h expected 0", tag, a, dbg_data_o);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear_sequence();
    rst = 1;
    run_clear("init");
    check_all_zero("init");
  endtask

  task automatic test_write_read();
    we_i = 1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF;
    cycle();
    we_i = 0; re1_i = 1; raddr1_i = 5'd5;
    #1;
    checks++;
    if (rdata1_o !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read_r5: got %h expected deadbeef", rdata1_o); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    we_i = 1; waddr_i = 5'd7; wdata_i = 32'h12345678;
    re1_i = 1; raddr1_i = 5'd7; re2_i = 1; raddr2_i = 5'd7;
    #1;
    checks++;
    if (rdata1_o !== 32'h12345678) begin errors++; $display("FAIL bypass_p1: got %h expected 12345678", rdata1_o); end
    checks++;
    if (rdata2_o !== 32'h12345678) begin errors++; $display("FAIL bypass_p2: got %h expected 12345678", rdata2_o); end
    cycle();
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    we_i = 1; waddr_i = 5'd0; wdata_i = 32'hFFFFFFFF; re1_i = 1; raddr1_i = 5'd0;
    #1;
    checks++;
    if (rdata1_o !== 32'd0) begin errors++; $display("FAIL r0_bypass: got %h expected 0", rdata1_o); end
    cycle();
    we_i = 0; re2_i = 1; raddr2_i = 5'd0; dbg_addr_i = 5'd0;
    #1;
    checks++;
    if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin
      errors++; $display("FAIL r0_read: got %h/%h expected 0/0", rdata1_o, rdata2_o);
    end
    cycle();
    checks++;
    if (dbg_data_o !== 32'd0) begin errors++; $display("FAIL r0_dbg: got %h expected 0", dbg_data_o); end
    idle_inputs();
  endtask

  task automatic test_read_disable_dbg();
    we_i = 1; waddr_i = 5'd9; wdata_i = 32'hA5A5A5A5; re1_i = 0; raddr1_i = 5'd9;
    #1;
    checks++;
    if (rdata1_o !== 32'd0) begin errors++; $display("FAIL re_off_bypass: got %h expected 0", rdata1_o); end
    cycle();
    we_i = 0; dbg_addr_i = 5'd9;
    #1;
    checks++;
    if (rdata1_o !== 32'd0) begin errors++; $display("FAIL re_off_read: got %h expected 0", rdata1_o); end
    cycle();
    checks++;
    if (dbg_data_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL dbg_r9: got %h expected a5a5a5a5", dbg_data_o); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      we_i = 1'($urandom); waddr_i = 5'($urandom); wdata_i = $urandom;
      re1_i = ($urandom_range(0, 7) != 0);
      raddr1_i = ($urandom_range(0, 3) == 0) ? waddr_i : 5'($urandom);
      re2_i = ($urandom_range(0, 7) != 0);
      raddr2_i = ($urandom_range(0, 3) == 0) ? raddr1_i : 5'($urandom);
      dbg_addr_i = ($urandom_range(0, 3) == 0) ? waddr_i : 5'($urandom);
      #1;
      e1 = exp_rd(re1_i, raddr1_i);
      e2 = exp_rd(re2_i, raddr2_i);
      checks++;
      if (rdata1_o !== e1) begin
        errors++; $display("FAIL rand_p1 it %0d addr %0d: got %h expected %h", n, raddr1_i, rdata1_o, e1);
      end
      checks++;
      if (rdata2_o !== e2) begin
        errors++; $display("FAIL rand_p2 it %0d addr %0d: got %h expected %h", n, raddr2_i, rdata2_o, e2);
      end
      cycle();
      checks++;
      if (dbg_data_o !== m_dbg || ready_o !== 1'b1) begin
        errors++; $display("FAIL rand_dbg it %0d: got %h/%b expected %h/1", n, dbg_data_o, ready_o, m_dbg);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 1; a < 32; a++) begin
      we_i = 1; waddr_i = 5'(a); wdata_i = $urandom | 32'h1;
      cycle();
    end
    idle_inputs();
    rst = 0; re1_i = 1; raddr1_i = 5'd12; re2_i = 1; raddr2_i = 5'd31;
    #1;
    checks++;
    if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0 || ready_o !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready: got %h/%h/%b expected 0/0/0", rdata1_o, rdata2_o, ready_o);
    end
    cycle();
    rst = 1;
    for (int k = 0; k < 10; k++) cycle();
    rst = 0;
    cycle();
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL mid_clear_ready: got %b expected 0", ready_o); end
    rst = 1;
    run_clear("restart");
    check_all_zero("restart");
  endtask

  task automatic test_no_clear_param();
    checks++;
    if (nc_ready !== 1'b0) begin errors++; $display("FAIL nc_reset_ready: got %b expected 0", nc_ready); end
    rst_nc = 1;
    #1;
    checks++;
    if (nc_ready !== 1'b1) begin errors++; $display("FAIL nc_ready_immediate: got %b expected 1", nc_ready); end
    checks++;
    if (nc_dbg !== 32'd0 || nc_rdata1 !== 32'd0 || nc_rdata2 !== 32'd0) begin
      errors++; $display("FAIL nc_outputs: got %h/%h/%h expected 0/0/0", nc_dbg, nc_rdata1, nc_rdata2);
    end
  endtask

  initial begin
    rst_nc = 0;
    test_reset();
    test_clear_sequence();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_read_disable_dbg();
    test_random();
    test_reset_mid_clear();
    test_no_clear_param();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
